// File: rtl/cdu_pkg.sv
// ---------------------------------------------------------------------------
// cdu_pkg
// Definitions shared by the CDU read counter and its coarse switch decoder.
//   CNT_W       : width of the read counter. One LSB is 360/2^16 degrees.
//   cdu_state_t : read counter FSM states. SETTLE waits for the analog inputs
//                 to settle. EVAL samples the inputs and takes at most one step.
//   OCT_SW_TBL  : octant cnt[15:13] -> sin/cos switch closures _DC1.._DC8.
//                 Bit n-1 of each entry drives _DCn.
// ---------------------------------------------------------------------------
package cdu_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_EVAL   = 1'b1
  } cdu_state_t;

  localparam logic [7:0] OCT_SW_TBL [0:7] = '{
    8'h14,  // k0: DC3, DC5
    8'h28,  // k1: DC4, DC6
    8'h22,  // k2: DC2, DC6
    8'h11,  // k3: DC1, DC5
    8'h41,  // k4: DC1, DC7
    8'h82,  // k5: DC2, DC8
    8'h88,  // k6: DC4, DC8
    8'h44   // k7: DC3, DC7
  };

endpackage

// File: rtl/coarse_switch_decode.sv
// ---------------------------------------------------------------------------
// coarse_switch_decode
// Combinational decode of the top seven read-counter bits into the switch
// closures of the coarse summing network.
// Ports:
//   i_cnt_hi [6:0]  : cnt[15:9]
//   o_dc     [11:0] : bit n-1 drives _DCn. 1 = switch closed.
//                     [7:0]  is the octant sin/cos pair.
//                     [11:8] is the binary-weighted reference bias
//                            (_DC9.._DC12 = cnt[12], cnt[11], cnt[10], cnt[9]).
// ---------------------------------------------------------------------------
module coarse_switch_decode
  import cdu_pkg::*;
(
  input  logic [6:0]  i_cnt_hi,
  output logic [11:0] o_dc
);

  always_comb begin
    o_dc       = '0;
    o_dc[7:0]  = OCT_SW_TBL[i_cnt_hi[6:4]];
    o_dc[8]    = i_cnt_hi[3];
    o_dc[9]    = i_cnt_hi[2];
    o_dc[10]   = i_cnt_hi[1];
    o_dc[11]   = i_cnt_hi[0];
  end

endmodule

// File: rtl/read_counter.sv
// ---------------------------------------------------------------------------
// read_counter
// CDU read counter for one gimbal axis. It holds a 16-bit angle register that
// follows the resolver. A coarse error above threshold steps the counter
// toward the sign of the error. A fine request steps it only when the coarse
// error is below threshold. Every step is reported to the AGC as one
// up_pulse or dn_pulse.
//
// Optional feature (macro CDU_INPUT_SYNC_EN):
//   When defined, _TLC1H, _CSGNH, fine_up and fine_dn each pass through a
//   two-flop synchronizer before use. This adds 2 clocks of input latency.
//
// Parameters:
//   SETTLE_CYC : clocks to wait after a count or switch change before the
//                analog inputs are sampled (>= 1)
//   FINE_DIV   : minimum number of clocks between fine steps (>= 1)
//
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   _TLC1H       : coarse error above threshold
//   _CSGNH       : coarse error sign (1 = up, 0 = down)
//   fine_up      : fine request, +1 LSB
//   fine_dn      : fine request, -1 LSB
//   zero         : synchronous clear; overrides any step
//   cnt[15:0]    : read counter value
//   _DC1.._DC12  : coarse switch closures, registered decode of cnt
//   up_pulse     : one-cycle pulse per +1 step
//   dn_pulse     : one-cycle pulse per -1 step
// ---------------------------------------------------------------------------
module read_counter
  import cdu_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned FINE_DIV   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             _TLC1H,
  input  logic             _CSGNH,
  input  logic             fine_up,
  input  logic             fine_dn,
  input  logic             zero,
  output logic [CNT_W-1:0] cnt,
  output logic             _DC1,
  output logic             _DC2,
  output logic             _DC3,
  output logic             _DC4,
  output logic             _DC5,
  output logic             _DC6,
  output logic             _DC7,
  output logic             _DC8,
  output logic             _DC9,
  output logic             _DC10,
  output logic             _DC11,
  output logic             _DC12,
  output logic             up_pulse,
  output logic             dn_pulse
);

  localparam int unsigned ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned FD_W = (FINE_DIV > 1) ? $clog2(FINE_DIV) : 1;
  localparam logic [ST_W-1:0] ST_RELOAD = ST_W'(SETTLE_CYC - 1);
  localparam logic [FD_W-1:0] FD_RELOAD = FD_W'(FINE_DIV - 1);

  cdu_state_t        r_state;
  cdu_state_t        w_state_nxt;
  logic [ST_W-1:0]   r_settle_tmr;
  logic [FD_W-1:0]   r_fine_tmr;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [11:0]       r_dc;
  logic [11:0]       w_dc_nxt;
  logic              r_up_pulse;
  logic              r_dn_pulse;
  logic [3:0]        w_in;
  logic              w_tlc, w_sgn, w_fup, w_fdn;
  logic              w_step_up, w_step_dn, w_step, w_fine_step;

`ifdef CDU_INPUT_SYNC_EN
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {_TLC1H, _CSGNH, fine_up, fine_dn};
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = {_TLC1H, _CSGNH, fine_up, fine_dn};
`endif

  assign {w_tlc, w_sgn, w_fup, w_fdn} = w_in;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SETTLE;
    else        r_state <= w_state_nxt;
  end

  // Step decision. At most one step per EVAL cycle. A coarse step overrides
  // a fine step, and zero blocks both.
  always_comb begin
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;
    w_fine_step = 1'b0;
    if (!zero && r_state == ST_EVAL) begin
      if (w_tlc) begin
        w_step_up = w_sgn;
        w_step_dn = !w_sgn;
      end else if ((w_fup ^ w_fdn) && r_fine_tmr == '0) begin
        w_fine_step = 1'b1;
        w_step_up   = w_fup;
        w_step_dn   = w_fdn;
      end
    end
  end

  assign w_step = w_step_up | w_step_dn;

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    if (zero || w_step)
      w_state_nxt = ST_SETTLE;
    else if (r_state == ST_SETTLE && r_settle_tmr == '0)
      w_state_nxt = ST_EVAL;
  end

  // Next count. The switch decode is taken from this value, so _DC changes
  // on the same edge as cnt.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (zero)           w_cnt_nxt = '0;
    else if (w_step_up) w_cnt_nxt = r_cnt + CNT_W'(1);
    else if (w_step_dn) w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  coarse_switch_decode u_decode (
    .i_cnt_hi (w_cnt_nxt[15:9]),
    .o_dc     (w_dc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_dc         <= {4'b0000, OCT_SW_TBL[0]};
      r_up_pulse   <= 1'b0;
      r_dn_pulse   <= 1'b0;
      r_settle_tmr <= ST_RELOAD;
      r_fine_tmr   <= FD_RELOAD;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_dc       <= w_dc_nxt;
      r_up_pulse <= w_step_up;
      r_dn_pulse <= w_step_dn;

      if (zero || w_step)
        r_settle_tmr <= ST_RELOAD;
      else if (r_state == ST_SETTLE && r_settle_tmr != '0)
        r_settle_tmr <= r_settle_tmr - ST_W'(1);

      // Free-runs down and saturates at 0. Only a fine step reloads it.
      if (w_fine_step)
        r_fine_tmr <= FD_RELOAD;
      else if (r_fine_tmr != '0)
        r_fine_tmr <= r_fine_tmr - FD_W'(1);
    end
  end

  assign cnt      = r_cnt;
  assign up_pulse = r_up_pulse;
  assign dn_pulse = r_dn_pulse;
  assign {_DC12, _DC11, _DC10, _DC9, _DC8, _DC7,
          _DC6, _DC5, _DC4, _DC3, _DC2, _DC1} = r_dc;

endmodule
